// File: rtl/inst_sequencer.sv
// -----------------------------------------------------------------------------
// inst_sequencer
//
// Multi-cycle instruction sequencer for a simple in-order core. It fetches one
// instruction at a time from an instruction memory, presents it to the decoder,
// and then either retires it through a write-back cycle or halts. Halting is
// either normal (ebreak) or a trap: illegal instruction, fetch timeout, or a
// misaligned PC. Once halted, the block does nothing until the next reset.
//
// Per-instruction flow: FETCH_REQ -> FETCH_WAIT -> EXEC -> WB -> FETCH_REQ.
//
// Handshake: a request transfers on a rising edge where imem_req_valid and
// imem_req_ready are both 1. Once imem_req_valid is raised it stays raised,
// with imem_req_addr unchanged, until that transfer happens. The response side
// has no ready signal: imem_resp_valid is a one-cycle strobe, and it is only
// acted on in FETCH_WAIT. In every other state it is ignored.
//
// Parameters
//   RESET_PC       PC loaded on reset.
//   FETCH_TIMEOUT  Number of FETCH_WAIT cycles without a response after which
//                  the block traps. Legal range is 1..255.
//
// Ports
//   clk              single clock; all state updates happen on its rising edge
//   rst              asynchronous reset, active low
//   imem_req_valid   out: fetch request pending
//   imem_req_ready   in : memory accepts the request this cycle
//   imem_req_addr    out: fetch address (always equal to pc)
//   imem_resp_valid  in : imem_resp_data holds the fetched word
//   imem_resp_data   in : fetched instruction word
//   inst             out: latched instruction, driven to the decoder
//   is_ebreak        in : decoder flag, inst is an ebreak
//   inst_not_ipl     in : decoder flag, inst is unimplemented
//   next_pc          in : successor PC computed by the datapath
//   pc               out: architectural PC
//   rf_wen           out: register-file write enable (WB only)
//   retire           out: one-cycle pulse for each retired instruction
//   instret          out: retired-instruction count; wraps modulo 2^64
//   halted           out: sticky, set when HALT is entered
//   trap             out: the halt was abnormal
//   trap_cause       out: 0 none, 1 illegal, 2 fetch timeout, 3 misaligned PC
//   state_dbg        out: current FSM state, for debug and checkers
// -----------------------------------------------------------------------------
module inst_sequencer #(
    parameter logic [63:0] RESET_PC      = 64'h8000_0000,
    parameter logic [7:0]  FETCH_TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] inst,
    input  logic        is_ebreak,
    input  logic        inst_not_ipl,
    input  logic [63:0] next_pc,
    output logic [63:0] pc,
    output logic        rf_wen,
    output logic        retire,
    output logic [63:0] instret,
    output logic        halted,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        FETCH_REQ  = 3'd0,
        FETCH_WAIT = 3'd1,
        EXEC       = 3'd2,
        WB         = 3'd3,
        HALT       = 3'd4
    } state_t;

    localparam logic [31:0] NOP_INST    = 32'h0000_0013;
    localparam logic [1:0]  CAUSE_NONE  = 2'd0;
    localparam logic [1:0]  CAUSE_ILL   = 2'd1;
    localparam logic [1:0]  CAUSE_TMO   = 2'd2;
    localparam logic [1:0]  CAUSE_ALIGN = 2'd3;

    state_t      state;
    state_t      state_next;
    logic [7:0]  wait_cnt;

    // Control strobes produced by the next-state logic.
    logic        latch_inst;
    logic        load_pc;
    logic        enter_halt;
    logic        halt_trap;
    logic [1:0]  halt_cause;

    assign imem_req_addr = pc;
    assign state_dbg     = state;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FETCH_REQ;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next     = state;
        imem_req_valid = 1'b0;
        rf_wen         = 1'b0;
        retire         = 1'b0;
        latch_inst     = 1'b0;
        load_pc        = 1'b0;
        enter_halt     = 1'b0;
        halt_trap      = 1'b0;
        halt_cause     = CAUSE_NONE;

        unique case (state)
            FETCH_REQ: begin
                if (pc[1:0] != 2'b00) begin
                    // A misaligned PC is never put on the bus.
                    state_next = HALT;
                    enter_halt = 1'b1;
                    halt_trap  = 1'b1;
                    halt_cause = CAUSE_ALIGN;
                end else begin
                    // Gated by rst so no request shows while reset is held.
                    imem_req_valid = rst;
                    if (imem_req_ready) begin
                        state_next = FETCH_WAIT;
                    end
                end
            end

            FETCH_WAIT: begin
                // A response that arrives in the timeout cycle takes priority.
                if (imem_resp_valid) begin
                    latch_inst = 1'b1;
                    state_next = EXEC;
                end else if (wait_cnt == FETCH_TIMEOUT - 8'd1) begin
                    state_next = HALT;
                    enter_halt = 1'b1;
                    halt_trap  = 1'b1;
                    halt_cause = CAUSE_TMO;
                end
            end

            EXEC: begin
                // An illegal instruction beats ebreak, and it does not retire.
                if (inst_not_ipl) begin
                    state_next = HALT;
                    enter_halt = 1'b1;
                    halt_trap  = 1'b1;
                    halt_cause = CAUSE_ILL;
                end else if (is_ebreak) begin
                    retire     = 1'b1;
                    state_next = HALT;
                    enter_halt = 1'b1;
                end else begin
                    state_next = WB;
                end
            end

            WB: begin
                rf_wen     = 1'b1;
                retire     = 1'b1;
                load_pc    = 1'b1;
                state_next = FETCH_REQ;
            end

            HALT: begin
                state_next = HALT;
            end

            default: begin
                state_next = HALT;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc         <= RESET_PC;
            inst       <= NOP_INST;
            instret    <= 64'd0;
            halted     <= 1'b0;
            trap       <= 1'b0;
            trap_cause <= CAUSE_NONE;
            wait_cnt   <= 8'd0;
        end else begin
            if (latch_inst) begin
                inst <= imem_resp_data;
            end
            if (load_pc) begin
                pc <= next_pc;
            end
            if (retire) begin
                instret <= instret + 64'd1;
            end
            if (enter_halt) begin
                halted     <= 1'b1;
                trap       <= halt_trap;
                trap_cause <= halt_cause;
            end
            // Outside FETCH_WAIT the counter is held at zero, so it always
            // starts a wait from zero. Inside FETCH_WAIT it counts the cycles
            // that pass without a response.
            if (state == FETCH_WAIT && !imem_resp_valid) begin
                wait_cnt <= wait_cnt + 8'd1;
            end else begin
                wait_cnt <= 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_inst_sequencer.sv
// -----------------------------------------------------------------------------
// tb_inst_sequencer
//
// Self-checking bench for inst_sequencer, built with FETCH_TIMEOUT = 4.
// The reference model works at instruction level. It keeps the expected pc,
// the retire count, and a queue of successor PCs that fall due after each
// write-back. Each cycle, inputs are driven just after the falling edge and
// outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_inst_sequencer;

    localparam logic [63:0] RESET_PC = 64'h8000_0000;
    localparam int          TO       = 4;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic [31:0] inst;
    logic        is_ebreak;
    logic        inst_not_ipl;
    logic [63:0] next_pc;
    logic [63:0] pc;
    logic        rf_wen;
    logic        retire;
    logic [63:0] instret;
    logic        halted;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [2:0]  state_dbg;

    inst_sequencer #(
        .RESET_PC      (RESET_PC),
        .FETCH_TIMEOUT (8'(TO))
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst            (inst),
        .is_ebreak       (is_ebreak),
        .inst_not_ipl    (inst_not_ipl),
        .next_pc         (next_pc),
        .pc              (pc),
        .rf_wen          (rf_wen),
        .retire          (retire),
        .instret         (instret),
        .halted          (halted),
        .trap            (trap),
        .trap_cause      (trap_cause),
        .state_dbg       (state_dbg)
    );

    // Clock and reset defaults
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard and model state
    logic [63:0] exp_q[$];
    logic [63:0] m_pc;
    logic [63:0] m_instret;
    int          n_vec;
    int          n_err;

    // Driver tasks
    task automatic drive_cycle(input logic rdy, input logic rv, input logic [31:0] rd,
                               input logic eb, input logic il, input logic [63:0] npc);
        @(negedge clk);
        imem_req_ready  = rdy;
        imem_resp_valid = rv;
        imem_resp_data  = rd;
        is_ebreak       = eb;
        inst_not_ipl    = il;
        next_pc         = npc;
        #1;
    endtask

    task automatic idle_inputs();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'd0;
        is_ebreak       = 1'b0;
        inst_not_ipl    = 1'b0;
        next_pc         = 64'd0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        m_pc      = RESET_PC;
        m_instret = 64'd0;
        exp_q.delete();
    endtask

    // Tests
    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        if ({pc, inst, instret, halted, trap, trap_cause, imem_req_valid, rf_wen, retire} !==
            {RESET_PC, NOP, 64'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_values: pc=%h inst=%h instret=%0d halted=%b trap=%b cause=%0d valid=%b wen=%b ret=%b, want pc=%h inst=%h rest 0",
                     pc, inst, instret, halted, trap, trap_cause, imem_req_valid, rf_wen, retire, RESET_PC, NOP);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_vec++;
        if ({imem_req_valid, imem_req_addr} !== {1'b1, RESET_PC}) begin
            n_err++;
            $display("FAIL reset_first_req: valid=%b addr=%h, want 1 %h", imem_req_valid, imem_req_addr, RESET_PC);
        end
        m_pc      = RESET_PC;
        m_instret = 64'd0;
        exp_q.delete();
    endtask

    // Runs n ordinary instructions. The request stall and the response delay
    // are drawn from the given ranges. Inputs the DUT should ignore in a
    // given cycle are driven with random values.
    task automatic test_stream(input string name, input int n, input int rq_lo, input int rq_hi,
                               input int rs_lo, input int rs_hi, input logic [31:0] fixed_word,
                               input bit seq_pc);
        logic [31:0] word;
        logic [63:0] npc;
        int          rq;
        int          rs;
        for (int i = 0; i < n; i++) begin
            if (exp_q.size() > 0) m_pc = exp_q.pop_front();
            rq   = int'($urandom_range(rq_hi, rq_lo));
            rs   = int'($urandom_range(rs_hi, rs_lo));
            word = (fixed_word != 32'd0) ? fixed_word : $urandom;
            npc  = seq_pc ? m_pc + 64'd4 : ({m_pc[63:32], $urandom} & ~64'd3);
            for (int k = 0; k <= rq; k++) begin
                drive_cycle(k == rq, 1'($urandom), $urandom, 1'($urandom), 1'($urandom), {$urandom, $urandom});
                n_vec++;
                if ({imem_req_valid, imem_req_addr, rf_wen, retire, pc, instret} !==
                    {1'b1, m_pc, 2'b00, m_pc, m_instret}) begin
                    n_err++;
                    $display("FAIL %s_fetch: valid=%b addr=%h wen=%b ret=%b pc=%h instret=%0d, want 1 %h 0 0 %h %0d",
                             name, imem_req_valid, imem_req_addr, rf_wen, retire, pc, instret, m_pc, m_pc, m_instret);
                end
            end
            for (int k = 0; k <= rs; k++) begin
                drive_cycle(1'($urandom), k == rs, (k == rs) ? word : $urandom, 1'($urandom), 1'($urandom), {$urandom, $urandom});
                n_vec++;
                if ({imem_req_valid, rf_wen, retire, halted} !== 4'b0000) begin
                    n_err++;
                    $display("FAIL %s_wait: valid=%b wen=%b ret=%b halted=%b, want all 0",
                             name, imem_req_valid, rf_wen, retire, halted);
                end
            end
            drive_cycle(1'($urandom), 1'($urandom), $urandom, 1'b0, 1'b0, {$urandom, $urandom});
            n_vec++;
            if ({inst, rf_wen, retire, imem_req_valid} !== {word, 3'b000}) begin
                n_err++;
                $display("FAIL %s_exec: inst=%h wen=%b ret=%b valid=%b, want %h 0 0 0",
                         name, inst, rf_wen, retire, imem_req_valid, word);
            end
            drive_cycle(1'($urandom), 1'($urandom), $urandom, 1'($urandom), 1'($urandom), npc);
            n_vec++;
            if ({rf_wen, retire, imem_req_valid} !== 3'b110) begin
                n_err++;
                $display("FAIL %s_wb: wen=%b ret=%b valid=%b, want 1 1 0", name, rf_wen, retire, imem_req_valid);
            end
            exp_q.push_back(npc);
            m_instret = m_instret + 64'd1;
        end
        if (exp_q.size() > 0) m_pc = exp_q.pop_front();
        drive_cycle(1'b0, 1'($urandom), $urandom, 1'($urandom), 1'($urandom), {$urandom, $urandom});
        n_vec++;
        if ({pc, instret, imem_req_valid} !== {m_pc, m_instret, 1'b1}) begin
            n_err++;
            $display("FAIL %s_final: pc=%h instret=%0d valid=%b, want %h %0d 1",
                     name, pc, instret, imem_req_valid, m_pc, m_instret);
        end
    endtask

    task automatic test_illegal(input logic eb);
        logic [31:0] word;
        apply_reset();
        test_stream("pre_illegal", 1, 0, 1, 0, 1, 32'd0, 1'b0);
        word = $urandom;
        drive_cycle(1'b1, 1'b0, $urandom, 1'($urandom), 1'($urandom), {$urandom, $urandom});
        drive_cycle(1'b0, 1'b1, word, 1'($urandom), 1'($urandom), {$urandom, $urandom});
        drive_cycle(1'b0, 1'b0, $urandom, eb, 1'b1, {$urandom, $urandom});
        n_vec++;
        if ({retire, rf_wen} !== 2'b00) begin
            n_err++;
            $display("FAIL illegal_exec: ret=%b wen=%b (ebreak=%b), want 0 0", retire, rf_wen, eb);
        end
        for (int k = 0; k < 4; k++) begin
            drive_cycle(1'($urandom), 1'($urandom), $urandom, 1'($urandom), 1'($urandom), {$urandom, $urandom});
            n_vec++;
            if ({halted, trap, trap_cause, imem_req_valid, retire, rf_wen, pc, instret, inst} !==
                {1'b1, 1'b1, 2'd1, 3'b000, m_pc, m_instret, word}) begin
                n_err++;
                $display("FAIL illegal_halt: halted=%b trap=%b cause=%0d valid=%b ret=%b wen=%b pc=%h instret=%0d inst=%h, want 1 1 1 0 0 0 %h %0d %h",
                         halted, trap, trap_cause, imem_req_valid, retire, rf_wen, pc, instret, inst, m_pc, m_instret, word);
            end
        end
    endtask

    task automatic test_ebreak();
        apply_reset();
        test_stream("pre_ebreak", 2, 0, 1, 0, 1, 32'd0, 1'b0);
        drive_cycle(1'b1, 1'b0, $urandom, 1'($urandom), 1'($urandom), {$urandom, $urandom});
        drive_cycle(1'b0, 1'b1, 32'h0010_0073, 1'($urandom), 1'($urandom), {$urandom, $urandom});
        drive_cycle(1'b0, 1'b0, $urandom, 1'b1, 1'b0, {$urandom, $urandom});
        n_vec++;
        if ({retire, rf_wen} !== 2'b10) begin
            n_err++;
            $display("FAIL ebreak_exec: ret=%b wen=%b, want 1 0", retire, rf_wen);
        end
        m_instret = m_instret + 64'd1;
        for (int k = 0; k < 4; k++) begin
            drive_cycle(1'b1, 1'($urandom), $urandom, 1'($urandom), 1'($urandom), {$urandom, $urandom});
            n_vec++;
            if ({halted, trap, trap_cause, imem_req_valid, retire, rf_wen, pc, instret} !==
                {1'b1, 1'b0, 2'd0, 3'b000, m_pc, m_instret}) begin
                n_err++;
                $display("FAIL ebreak_halt: halted=%b trap=%b cause=%0d valid=%b ret=%b wen=%b pc=%h instret=%0d, want 1 0 0 0 0 0 %h %0d",
                         halted, trap, trap_cause, imem_req_valid, retire, rf_wen, pc, instret, m_pc, m_instret);
            end
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        drive_cycle(1'b1, 1'b0, $urandom, 1'b0, 1'b0, 64'd0);
        n_vec++;
        if ({imem_req_valid, imem_req_addr} !== {1'b1, RESET_PC}) begin
            n_err++;
            $display("FAIL timeout_req: valid=%b addr=%h, want 1 %h", imem_req_valid, imem_req_addr, RESET_PC);
        end
        for (int k = 0; k < TO; k++) begin
            drive_cycle(1'($urandom), 1'b0, $urandom, 1'($urandom), 1'($urandom), {$urandom, $urandom});
            n_vec++;
            if ({halted, imem_req_valid} !== 2'b00) begin
                n_err++;
                $display("FAIL timeout_wait%0d: halted=%b valid=%b, want 0 0", k, halted, imem_req_valid);
            end
        end
        for (int k = 0; k < 3; k++) begin
            drive_cycle(1'($urandom), 1'b1, $urandom, 1'($urandom), 1'($urandom), {$urandom, $urandom});
            n_vec++;
            if ({halted, trap, trap_cause, imem_req_valid, inst, pc} !== {1'b1, 1'b1, 2'd2, 1'b0, NOP, RESET_PC}) begin
                n_err++;
                $display("FAIL timeout_halt: halted=%b trap=%b cause=%0d valid=%b inst=%h pc=%h, want 1 1 2 0 %h %h",
                         halted, trap, trap_cause, imem_req_valid, inst, pc, NOP, RESET_PC);
            end
        end
    endtask

    task automatic test_misaligned();
        logic [63:0] bad_pc;
        apply_reset();
        bad_pc = RESET_PC + 64'($urandom_range(3, 1));
        drive_cycle(1'b1, 1'b0, $urandom, 1'b0, 1'b0, 64'd0);
        drive_cycle(1'b0, 1'b1, $urandom, 1'b0, 1'b0, 64'd0);
        drive_cycle(1'b0, 1'b0, $urandom, 1'b0, 1'b0, 64'd0);
        drive_cycle(1'b0, 1'b0, $urandom, 1'b0, 1'b0, bad_pc);
        n_vec++;
        if (rf_wen !== 1'b1) begin
            n_err++;
            $display("FAIL misaligned_wb: wen=%b, want 1", rf_wen);
        end
        drive_cycle(1'b1, 1'b0, $urandom, 1'b0, 1'b0, 64'd0);
        n_vec++;
        if ({imem_req_valid, pc, halted} !== {1'b0, bad_pc, 1'b0}) begin
            n_err++;
            $display("FAIL misaligned_req: valid=%b pc=%h halted=%b, want 0 %h 0", imem_req_valid, pc, halted, bad_pc);
        end
        for (int k = 0; k < 2; k++) begin
            drive_cycle(1'b1, 1'($urandom), $urandom, 1'($urandom), 1'($urandom), {$urandom, $urandom});
            n_vec++;
            if ({halted, trap, trap_cause, imem_req_valid, pc, instret} !== {1'b1, 1'b1, 2'd3, 1'b0, bad_pc, 64'd1}) begin
                n_err++;
                $display("FAIL misaligned_halt: halted=%b trap=%b cause=%0d valid=%b pc=%h instret=%0d, want 1 1 3 0 %h 1",
                         halted, trap, trap_cause, imem_req_valid, pc, instret, bad_pc);
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        test_stream("pre_rst", 2, 0, 2, 0, 2, 32'd0, 1'b0);
        drive_cycle(1'b1, 1'b0, $urandom, 1'b0, 1'b0, 64'd0);
        drive_cycle(1'b0, 1'b0, $urandom, 1'b0, 1'b0, 64'd0);
        // Reset asserted between clock edges, in the middle of FETCH_WAIT.
        rst = 1'b0;
        #1;
        n_vec++;
        if ({pc, instret, inst, halted, imem_req_valid} !== {RESET_PC, 64'd0, NOP, 2'b00}) begin
            n_err++;
            $display("FAIL reset_async: pc=%h instret=%0d inst=%h halted=%b valid=%b, want %h 0 %h 0 0",
                     pc, instret, inst, halted, imem_req_valid, RESET_PC, NOP);
        end
        @(negedge clk);
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hdead_beef;
        @(negedge clk);
        rst = 1'b1;
        m_pc      = RESET_PC;
        m_instret = 64'd0;
        exp_q.delete();
        for (int k = 0; k < 2; k++) begin
            drive_cycle(1'b0, 1'b1, 32'hdead_beef, 1'($urandom), 1'($urandom), {$urandom, $urandom});
            n_vec++;
            if ({imem_req_valid, imem_req_addr, inst} !== {1'b1, RESET_PC, NOP}) begin
                n_err++;
                $display("FAIL reset_stale: valid=%b addr=%h inst=%h, want 1 %h %h",
                         imem_req_valid, imem_req_addr, inst, RESET_PC, NOP);
            end
        end
        test_stream("post_rst", 1, 0, 0, 0, 0, 32'd0, 1'b1);
    endtask

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    // Sequencer
    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b0;
        idle_inputs();
        test_reset();
        test_stream("back_to_back", 4, 0, 0, 0, 0, 32'h0010_0093, 1'b1);
        test_stream("stall", 1, 5, 5, 0, 0, 32'd0, 1'b1);
        test_stream("resp_wins", 1, 0, 0, TO - 1, TO - 1, 32'd0, 1'b0);
        test_stream("random", 30, 0, 4, 0, TO - 1, 32'd0, 1'b0);
        test_illegal(1'b1);
        test_illegal(1'b0);
        test_ebreak();
        test_timeout();
        test_misaligned();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
